// File: rtl/sccb_resp_if.sv
// rtl/sccb_resp_if.sv - SCCB responder pin and write-report signal bundle
interface sccb_resp_if;
    logic        I_SCL;
    logic        I_SDA;
    logic        O_SDA;
    logic        O_SDA_OE;
    logic        O_WR_EN;
    logic [15:0] O_WR_ADDR;
    logic [7:0]  O_WR_DATA;
    logic        O_BUSY;

    modport slave (
        input  I_SCL, I_SDA,
        output O_SDA, O_SDA_OE, O_WR_EN, O_WR_ADDR, O_WR_DATA, O_BUSY
    );

    modport master (
        output I_SCL, I_SDA,
        input  O_SDA, O_SDA_OE, O_WR_EN, O_WR_ADDR, O_WR_DATA, O_BUSY
    );
endinterface

// File: rtl/sccb_resp.sv
// rtl/sccb_resp.sv - SCCB target: decodes ID/ADDR_H/ADDR_L frames, writes or reads a register array
module sccb_resp #(
    parameter logic [6:0] P_SLAVE_ADDR = 7'h3C,
    parameter int         P_ADDR_W     = 8,
    parameter bit         P_ACK_EN     = 1'b1,
    parameter int         P_TIMEOUT    = 1000
) (
    input  logic       CLK,
    input  logic       RSTn,
    sccb_resp_if.slave bus
);
    localparam int TW    = $clog2(P_TIMEOUT + 1);
    localparam int DEPTH = 2 ** P_ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_ID, S_ADDR_H, S_ADDR_L, S_WDATA, S_RDATA, S_IGNORE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    scl_sync_q, sda_sync_q;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    rd_sh_q, rd_sh_d;
    logic          rw_q, rw_d;
    logic [15:0]   addr_q, addr_d;
    logic          sda_o_q, sda_o_d;
    logic          oe_q, oe_d;
    logic          wr_en_q, wr_en_d;
    logic [15:0]   wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    mem_q [DEPTH];
    logic          mem_we, tmo_hit;

    // [0],[1] are the synchroniser stages, [2] is the edge-detect copy
    logic scl, scl_rise, scl_fall, sda_rise, sda_fall, start_ev, stop_ev, in_range;
    logic [7:0] rx_byte, rd_word;

    assign scl      = scl_sync_q[1];
    assign scl_rise =  scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall = ~scl_sync_q[1] &  scl_sync_q[2];
    assign sda_rise =  sda_sync_q[1] & ~sda_sync_q[2];
    assign sda_fall = ~sda_sync_q[1] &  sda_sync_q[2];
    assign start_ev = sda_fall & scl;
    assign stop_ev  = sda_rise & scl;
    assign rx_byte  = {rx_sh_q, sda_sync_q[1]};
    assign in_range = (addr_q >> P_ADDR_W) == 16'd0;
    assign rd_word  = in_range ? mem_q[addr_q[P_ADDR_W-1:0]] : 8'h00;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], bus.I_SCL};
            sda_sync_q <= {sda_sync_q[1:0], bus.I_SDA};
        end
    end

    // bit_cnt counts SCL rises in the current byte: 8 = data done, 9 = ACK slot high seen
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_sh_d   = rx_sh_q;
        rd_sh_d   = rd_sh_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        sda_o_d   = sda_o_q;
        oe_d      = oe_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;
        tmo_d     = tmo_q + 1'b1;
        if (state_q == S_IDLE || !scl || scl_rise || sda_rise || sda_fall)
            tmo_d = '0;
        tmo_hit = (tmo_d == TW'(P_TIMEOUT));

        if (start_ev) begin
            state_d   = S_ID;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
            sda_o_d   = 1'b1;
            tmo_d     = '0;
        end else if (stop_ev || tmo_hit) begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
            sda_o_d   = 1'b1;
            tmo_d     = '0;
        end else begin
            if (scl_rise && bit_cnt_q != 4'd9 && state_q != S_IDLE && state_q != S_IGNORE)
                bit_cnt_d = bit_cnt_q + 4'd1;
            case (state_q)
                S_ID, S_ADDR_H, S_ADDR_L, S_WDATA: begin
                    if (scl_rise && bit_cnt_q < 4'd8)
                        rx_sh_d = rx_byte[6:0];
                    if (scl_rise && bit_cnt_q == 4'd7) begin
                        case (state_q)
                            S_ID: begin
                                if (rx_byte[7:1] != P_SLAVE_ADDR) state_d = S_IGNORE;
                                else                              rw_d    = rx_byte[0];
                            end
                            S_ADDR_H: addr_d[15:8] = rx_byte;
                            S_ADDR_L: addr_d[7:0]  = rx_byte;
                            default: begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = rx_byte;
                                mem_we    = in_range;
                            end
                        endcase
                    end
                    if (scl_fall && bit_cnt_q == 4'd8 && P_ACK_EN) begin
                        oe_d    = 1'b1;
                        sda_o_d = 1'b0;
                    end
                    if (scl_fall && bit_cnt_q == 4'd9) begin
                        oe_d      = 1'b0;
                        sda_o_d   = 1'b1;
                        bit_cnt_d = 4'd0;
                        case (state_q)
                            S_ID:     state_d = S_ADDR_H;
                            S_ADDR_H: state_d = S_ADDR_L;
                            S_ADDR_L: begin
                                if (rw_q) begin
                                    state_d = S_WDATA;
                                end else begin
                                    state_d = S_RDATA;
                                    rd_sh_d = rd_word;
                                    sda_o_d = rd_word[7];
                                    oe_d    = 1'b1;
                                end
                            end
                            default:  state_d = S_IGNORE;
                        endcase
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd7) begin
                            rd_sh_d = {rd_sh_q[6:0], rd_sh_q[7]};
                            sda_o_d = rd_sh_q[6];
                        end else if (bit_cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            sda_o_d = 1'b1;
                        end else if (bit_cnt_q == 4'd9) begin
                            state_d   = S_IGNORE;
                            bit_cnt_d = 4'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 4'd0;
            rx_sh_q   <= 7'd0;
            rd_sh_q   <= 8'd0;
            rw_q      <= 1'b0;
            addr_q    <= 16'd0;
            sda_o_q   <= 1'b1;
            oe_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 16'd0;
            wr_data_q <= 8'd0;
            tmo_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_sh_q   <= rx_sh_d;
            rd_sh_q   <= rd_sh_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            sda_o_q   <= sda_o_d;
            oe_q      <= oe_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            tmo_q     <= tmo_d;
            if (mem_we) mem_q[addr_q[P_ADDR_W-1:0]] <= wr_data_d;
        end
    end

    assign bus.O_SDA     = sda_o_q;
    assign bus.O_SDA_OE  = oe_q;
    assign bus.O_WR_EN   = wr_en_q;
    assign bus.O_WR_ADDR = wr_addr_q;
    assign bus.O_WR_DATA = wr_data_q;
    assign bus.O_BUSY    = (state_q != S_IDLE);
endmodule

// File: tb/tb_sccb_resp.sv
// tb/tb_sccb_resp.sv - self-checking bench for sccb_resp with an SCCB initiator model
module tb_sccb_resp;
    localparam int H   = 10;
    localparam int TMO = 1000;

    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    logic m_sda = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   oe_seen = 1'b0;
    bit   wr_prev = 1'b0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;
    wr_t wr_q[$];

    typedef struct {
        bit          rd;
        logic [7:0]  id;
        logic [15:0] addr;
        logic [7:0]  data;
        int          exp_acks;
        logic [7:0]  exp_rd;
        bit          exp_wr;
    } vec_t;
    vec_t vecs[10];

    sccb_resp_if bus();

    sccb_resp dut (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // open-drain bus: either side can pull SDA low
    assign bus.I_SDA = m_sda & (bus.O_SDA_OE ? bus.O_SDA : 1'b1);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tk(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (bus.O_SDA_OE) oe_seen = 1'b1;
        if (bus.O_WR_EN) begin
            wr_t e;
            chk("wr_pulse_width", {31'd0, wr_prev}, 32'd0);
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", {16'd0, bus.O_WR_ADDR}, 32'hFFFF_FFFF);
            end else begin
                e = wr_q.pop_front();
                chk("wr_addr", {16'd0, bus.O_WR_ADDR}, {16'd0, e.addr});
                chk("wr_data", {24'd0, bus.O_WR_DATA}, {24'd0, e.data});
            end
        end
        wr_prev = bus.O_WR_EN;
    end

    task automatic bus_start();
        m_sda = 1'b1; bus.I_SCL = 1'b1; tk(H);
        m_sda = 1'b0; tk(H);
        bus.I_SCL = 1'b0; tk(H/2);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; tk(H/2);
        bus.I_SCL = 1'b1; tk(H);
        m_sda = 1'b1; tk(H);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; tk(H/2);
        bus.I_SCL = 1'b1; tk(H);
        bus.I_SCL = 1'b0; tk(H/2);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; tk(H/2);
        bus.I_SCL = 1'b1; tk(H/2);
        acked = (bus.I_SDA == 1'b0);
        tk(H/2);
        bus.I_SCL = 1'b0; tk(H/2);
    endtask

    task automatic recv_byte(output logic [7:0] b, output bit stable);
        stable = 1'b1;
        m_sda  = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tk(H/2);
            bus.I_SCL = 1'b1; tk(1);
            b[i] = bus.I_SDA;
            tk(H-2);
            if (bus.I_SDA !== b[i]) stable = 1'b0;
            tk(1);
            bus.I_SCL = 1'b0; tk(H/2);
        end
        tk(H/2);
        bus.I_SCL = 1'b1; tk(H/2);
        chk("rd_ack_slot_oe", {31'd0, bus.O_SDA_OE}, 32'd0);
        tk(H/2);
        bus.I_SCL = 1'b0; tk(H/2);
    endtask

    task automatic do_frame(input vec_t v, input bit with_stop, output int acks,
                            output logic [7:0] rd, output bit stable);
        bit a;
        acks    = 0;
        rd      = 8'h00;
        stable  = 1'b1;
        oe_seen = 1'b0;
        bus_start();
        send_byte(v.id, a);         acks += int'(a);
        send_byte(v.addr[15:8], a); acks += int'(a);
        send_byte(v.addr[7:0], a);  acks += int'(a);
        if (v.rd) begin
            recv_byte(rd, stable);
        end else begin
            if (v.exp_wr) wr_q.push_back('{v.addr, v.data});
            send_byte(v.data, a);   acks += int'(a);
        end
        if (with_stop) bus_stop();
    endtask

    task automatic read_check(input string name, input logic [15:0] addr, input logic [7:0] exp);
        vec_t v;
        int acks;
        logic [7:0] rd;
        bit st;
        v = '{1'b1, 8'h78, addr, 8'h00, 3, exp, 1'b0};
        do_frame(v, 1'b1, acks, rd, st);
        chk({name, "_acks"}, acks, 3);
        chk({name, "_data"}, {24'd0, rd}, {24'd0, exp});
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        logic [7:0] rd;
        bit st, a;

        vecs[0] = '{1'b0, 8'h79, 16'h0012, 8'hA5, 4, 8'h00, 1'b1};
        vecs[1] = '{1'b1, 8'h78, 16'h0012, 8'h00, 3, 8'hA5, 1'b0};
        vecs[2] = '{1'b0, 8'h42, 16'h0012, 8'h11, 0, 8'h00, 1'b0};
        vecs[3] = '{1'b1, 8'h78, 16'h0012, 8'h00, 3, 8'hA5, 1'b0};
        vecs[4] = '{1'b0, 8'h79, 16'h0123, 8'h77, 4, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 8'h78, 16'h0123, 8'h00, 3, 8'h00, 1'b0};
        vecs[6] = '{1'b1, 8'h78, 16'h0023, 8'h00, 3, 8'h00, 1'b0};
        vecs[7] = '{1'b0, 8'h79, 16'h00FF, 8'h5A, 4, 8'h00, 1'b1};
        vecs[8] = '{1'b1, 8'h78, 16'h00FF, 8'h00, 3, 8'h5A, 1'b0};
        vecs[9] = '{1'b0, 8'h7B, 16'h0012, 8'hEE, 0, 8'h00, 1'b0};

        bus.I_SCL = 1'b1;
        m_sda     = 1'b1;
        rstn      = 1'b0;
        tk(3);
        chk("rst_sda",     {31'd0, bus.O_SDA},     32'd1);
        chk("rst_oe",      {31'd0, bus.O_SDA_OE},  32'd0);
        chk("rst_wr_en",   {31'd0, bus.O_WR_EN},   32'd0);
        chk("rst_wr_addr", {16'd0, bus.O_WR_ADDR}, 32'd0);
        chk("rst_wr_data", {24'd0, bus.O_WR_DATA}, 32'd0);
        chk("rst_busy",    {31'd0, bus.O_BUSY},    32'd0);
        rstn = 1'b1;
        tk(5);

        for (int i = 0; i < 10; i++) begin
            do_frame(vecs[i], 1'b1, acks, rd, st);
            chk($sformatf("v%0d_acks", i), acks, vecs[i].exp_acks);
            if (vecs[i].rd) begin
                chk($sformatf("v%0d_rdata", i), {24'd0, rd}, {24'd0, vecs[i].exp_rd});
                chk($sformatf("v%0d_rd_stable", i), {31'd0, st}, 32'd1);
            end
            if (vecs[i].exp_acks == 0)
                chk($sformatf("v%0d_no_oe", i), {31'd0, oe_seen}, 32'd0);
            tk(4);
            chk($sformatf("v%0d_idle_after_stop", i), {31'd0, bus.O_BUSY}, 32'd0);
        end

        // mismatched ID parks the FSM in IGNORE until the stop
        bus_start();
        send_byte(8'h42, a);
        chk("ign_no_ack", {31'd0, a}, 32'd0);
        tk(H);
        chk("ign_busy", {31'd0, bus.O_BUSY}, 32'd1);
        bus_stop();
        tk(4);
        chk("ign_stop_idle", {31'd0, bus.O_BUSY}, 32'd0);

        // stop after ADDR_H aborts the write; the next full frame writes once
        bus_start();
        send_byte(8'h79, a);
        send_byte(8'h00, a);
        bus_stop();
        tk(4);
        chk("abort_idle", {31'd0, bus.O_BUSY}, 32'd0);
        do_frame('{1'b0, 8'h79, 16'h0001, 8'h3C, 4, 8'h00, 1'b1}, 1'b1, acks, rd, st);
        chk("after_abort_acks", acks, 4);
        read_check("after_abort_rd", 16'h0001, 8'h3C);

        // read frame with no stop: ends by timeout after SCL returns high
        do_frame(vecs[1], 1'b0, acks, rd, st);
        chk("tmo_rdata", {24'd0, rd}, 32'h0000_00A5);
        m_sda = 1'b1;
        tk(H/2);
        bus.I_SCL = 1'b1;
        tk(TMO - 10);
        chk("tmo_still_busy", {31'd0, bus.O_BUSY}, 32'd1);
        tk(20);
        chk("tmo_idle", {31'd0, bus.O_BUSY}, 32'd0);

        // reset in the middle of WDATA
        bus_start();
        send_byte(8'h79, a);
        send_byte(8'h00, a);
        send_byte(8'h40, a);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rstn = 1'b0;
        #1;
        chk("midrst_sda",     {31'd0, bus.O_SDA},     32'd1);
        chk("midrst_oe",      {31'd0, bus.O_SDA_OE},  32'd0);
        chk("midrst_wr_en",   {31'd0, bus.O_WR_EN},   32'd0);
        chk("midrst_wr_addr", {16'd0, bus.O_WR_ADDR}, 32'd0);
        chk("midrst_wr_data", {24'd0, bus.O_WR_DATA}, 32'd0);
        chk("midrst_busy",    {31'd0, bus.O_BUSY},    32'd0);
        bus.I_SCL = 1'b1;
        m_sda     = 1'b1;
        tk(5);
        rstn = 1'b1;
        tk(5);
        read_check("cleared_0012", 16'h0012, 8'h00);
        read_check("cleared_0001", 16'h0001, 8'h00);

        tk(10);
        chk("wr_queue_empty", wr_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sccb_resp.md
# sccb_resp

SCCB responder (camera-sensor-side target) for bench and loopback use against the on-chip SCCB initiator. Decodes the initiator's frame: ID byte, 16-bit register address, then one write-data byte or one read-data byte returned by the responder. It holds an internal register array and answers reads from it. It sits on the SCL/SDA pins opposite the initiator, either in simulation or in an FPGA loopback build.

## Interface
- P_SLAVE_ADDR, 7'h3C: 7-bit device ID matched against ID byte bits [7:1].
- P_ADDR_W, 8: register array depth is 2^P_ADDR_W bytes, indexed by address[P_ADDR_W-1:0].
- P_ACK_EN, 1: 1 = drive SDA low in the 9th bit of ID/ADDR_H/ADDR_L/WDATA; 0 = never drive ACK.
- P_TIMEOUT, 1000: CLK cycles of SCL held high with no SCL/SDA edge before the frame is aborted.
- CLK  in  1  system clock; single clock domain.
- RSTn  in  1  asynchronous, active-low reset.
- I_SCL  in  1  SCL from the bus; asynchronous.
- I_SDA  in  1  SDA from the bus; asynchronous.
- O_SDA  out  1  SDA drive value.
- O_SDA_OE  out  1  SDA output enable (1 = drive O_SDA).
- O_WR_EN  out  1  one-CLK pulse when a write byte completes.
- O_WR_ADDR  out  16  full 16-bit address of the completed write.
- O_WR_DATA  out  8  data of the completed write.
- O_BUSY  out  1  high while the FSM is not IDLE.

## Operation
- Synchronisation: I_SCL and I_SDA each pass through 2-FF synchronisers. Edges are detected on the sync output against its one-cycle-delayed copy.
- Bus events:
  - start = SDA falling while SCL high.
  - stop = SDA rising while SCL high.
  - A start in any state forces ID with bit count 0. Repeated start is accepted.
  - A stop in any state forces IDLE.
- Bits are sampled MSB first on the detected SCL rising edge. A 4-bit counter tracks bits 0..8; bit 8 is the ACK slot.
- FSM states: IDLE, ID, ADDR_H, ADDR_L, WDATA, RDATA, IGNORE.
- IDLE -> ID on start.
- ID, after the 8th rise:
  - id[7:1] != P_SLAVE_ADDR -> IGNORE.
  - On match, the rw bit id[0] is latched: 1 = write, 0 = read.
- Each byte state advances on the SCL falling edge that ends its ACK slot:
  - ID -> ADDR_H.
  - ADDR_H -> ADDR_L.
  - ADDR_L -> WDATA if rw = 1, RDATA if rw = 0. There is no repeated start before read data.
  - WDATA / RDATA -> IGNORE.
- Write commit happens on the 8th rise of WDATA, before the ACK slot:
  - O_WR_EN pulses with O_WR_ADDR and O_WR_DATA.
  - The array is written only if address[15:P_ADDR_W] == 0. The pulse is issued regardless.
- Read snapshot happens on the ADDR_L -> RDATA transition:
  - Loads array[address] into an 8-bit shift register, or 8'h00 if out of range.
  - Bit 7 is driven first.
- IGNORE: no drive and no writes until a start, stop, or timeout.
- Timeout: the counter runs while synced SCL = 1 and no SCL/SDA edge occurs. Reaching P_TIMEOUT forces IDLE; this is the normal end of an initiator frame that has no stop. Any edge clears the counter.
- Reset (asynchronous):
  - FSM = IDLE; all counters and shift registers 0; array all 8'h00.
  - O_SDA = 1, O_SDA_OE = 0, O_WR_EN = 0, O_WR_ADDR = 0, O_WR_DATA = 0, O_BUSY = 0.
  - Reset mid-frame abandons the frame with no write.

## Timing
- Pin-to-detect latency is 3 CLK: 2 sync stages plus the edge register. The SCL half-period must be at least 8 CLK.
- ACK drive:
  - O_SDA_OE = 1 and O_SDA = 0 are asserted 1 CLK after the detected falling edge that ends bit 7.
  - They are released 1 CLK after the detected falling edge that ends bit 8.
  - Applies only when P_ACK_EN = 1 and the state is ID(match), ADDR_H, ADDR_L or WDATA.
- Read drive:
  - Bit n is presented 1 CLK after the detected falling edge preceding its SCL high and is held stable through that high.
  - OE is released 1 CLK after the falling edge that ends bit 0. The responder never drives the ACK slot in RDATA.
- O_WR_EN rises 1 CLK after the detected 8th WDATA rise and lasts exactly 1 CLK. O_WR_ADDR and O_WR_DATA hold until the next write.
- Simultaneous start and timeout in the same cycle: start wins.

## Test plan
- Write 0x3C, address 0x0012, data 0xA5 -> O_WR_EN single pulse with ADDR 0x0012 and DATA 0xA5; ACK low in all four ACK slots; a later read of 0x0012 returns 0xA5.
- Read 0x3C(rw = 0), address 0x0012 after the prior write -> bits 1,0,1,0,0,1,0,1 on SDA while SCL high; OE low during the ACK slot; FSM reaches IDLE P_TIMEOUT cycles after the last edge.
- ID byte 0x42 -> no ACK, OE never asserted, no O_WR_EN, FSM in IGNORE until timeout or stop.
- Write to address 0x0123 with data 0x77 (out of range for P_ADDR_W = 8) -> O_WR_EN pulses with ADDR 0x0123; array unchanged; read of 0x0123 returns 0x00.
- Stop after ADDR_H of a write, then a fresh write frame to 0x0001 with data 0x3C -> no write from the aborted frame; a single write of 0x3C to 0x0001.
- RSTn asserted mid-WDATA -> outputs at reset values immediately; no O_WR_EN; array cleared.
